// File: rtl/lc2k_pkg.sv
// Shared LC2K definitions for the decode stage: opcodes, ALU operation encoding,
// instruction field positions and the 16-bit sign-extension helper.
package lc2k_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_NOR  = 3'd1;
  localparam logic [2:0] OP_LW   = 3'd2;
  localparam logic [2:0] OP_SW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_JALR = 3'd5;
  localparam logic [2:0] OP_HALT = 3'd6;
  localparam logic [2:0] OP_NOOP = 3'd7;

  typedef enum logic [1:0] {
    ALU_ADD    = 2'b00,
    ALU_NOR    = 2'b01,
    ALU_EQ     = 2'b10,
    ALU_PASS_A = 2'b11
  } alu_op_e;

  localparam int OP_MSB   = 24;
  localparam int OP_LSB   = 22;
  localparam int RA_MSB   = 21;
  localparam int RA_LSB   = 19;
  localparam int RB_MSB   = 18;
  localparam int RB_LSB   = 16;
  localparam int OFF_MSB  = 15;
  localparam int DEST_MSB = 2;

  function automatic logic [31:0] sign_extend16(input logic [15:0] value);
    return {{16{value[15]}}, value};
  endfunction

endpackage

// File: rtl/lc2k_regfile.sv
// LC2K register file: two asynchronous read ports, one synchronous write port, r0 reads 0.
// Define LC2K_WB_BYPASS_EN to make a same-cycle write visible on the read ports.
module lc2k_regfile #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AW-1:0]     rd_addr_a,
  input  logic [AW-1:0]     rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
    rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];
`ifdef LC2K_WB_BYPASS_EN
    if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
`endif
  end

endmodule

// File: rtl/lc2k_decode_stage.sv
// LC2K ID stage with ID/EX register: decode, register read, load-use hazard, flush, halt.
// Optional LC2K_WB_BYPASS_EN gives write-through reads from the WB port (see lc2k_regfile).
module lc2k_decode_stage
  import lc2k_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16,
  parameter int NREGS  = 8,
  parameter int AW     = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_instr,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] aluValA,
  output logic [DATA_W-1:0] aluValB,
  output logic [1:0]        CONTROL_OPERATION,
  output logic [DATA_W-1:0] offsetExtended,
  output logic [PC_W-1:0]   pcPrev,
  output logic [DATA_W-1:0] regB_data,
  output logic [AW-1:0]     dest_reg,
  output logic              wr_en,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              is_beq,
  output logic              is_jalr,
  output logic              halt,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_reg,
  input  logic [DATA_W-1:0] wb_data
);

  logic [2:0]        op;
  logic [AW-1:0]     reg_a;
  logic [AW-1:0]     reg_b;
  logic [AW-1:0]     reg_d;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] off_ext;
  logic              unused_instr;

  assign op           = in_instr[OP_MSB:OP_LSB];
  assign reg_a        = in_instr[RA_MSB:RA_LSB];
  assign reg_b        = in_instr[RB_MSB:RB_LSB];
  assign reg_d        = in_instr[DEST_MSB:0];
  assign off_ext      = sign_extend16(in_instr[OFF_MSB:0]);
  assign unused_instr = ^in_instr[31:25];

  lc2k_regfile #(.DATA_W(DATA_W), .NREGS(NREGS), .AW(AW)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .rd_addr_a (reg_a),
    .rd_addr_b (reg_b),
    .rd_data_a (rd_a),
    .rd_data_b (rd_b),
    .wr_en     (wb_en),
    .wr_addr   (wb_reg),
    .wr_data   (wb_data)
  );

  logic [DATA_W-1:0] dec_a, dec_b, dec_rbd;
  alu_op_e           dec_op;
  logic [AW-1:0]     dec_dest;
  logic              dec_wr, dec_mrd, dec_mwr, dec_beq, dec_jalr, dec_halt;
  logic              reads_a, reads_b;

  always_comb begin
    dec_a    = rd_a;
    dec_b    = rd_b;
    dec_rbd  = rd_b;
    dec_op   = ALU_ADD;
    dec_dest = '0;
    dec_wr   = 1'b0;
    dec_mrd  = 1'b0;
    dec_mwr  = 1'b0;
    dec_beq  = 1'b0;
    dec_jalr = 1'b0;
    dec_halt = 1'b0;
    reads_a  = (op <= OP_JALR);
    reads_b  = (op == OP_ADD) || (op == OP_NOR) || (op == OP_SW) || (op == OP_BEQ);
    case (op)
      OP_ADD:  begin dec_dest = reg_d; dec_wr = 1'b1; end
      OP_NOR:  begin dec_op = ALU_NOR; dec_dest = reg_d; dec_wr = 1'b1; end
      OP_LW:   begin dec_b = off_ext; dec_dest = reg_b; dec_wr = 1'b1; dec_mrd = 1'b1; end
      OP_SW:   begin dec_b = off_ext; dec_mwr = 1'b1; end
      OP_BEQ:  begin dec_op = ALU_EQ; dec_beq = 1'b1; end
      OP_JALR: begin dec_op = ALU_PASS_A; dec_dest = reg_b; dec_wr = 1'b1; dec_jalr = 1'b1; end
      OP_HALT: begin dec_a = '0; dec_b = '0; dec_rbd = '0; dec_halt = 1'b1; end
      default: begin dec_a = '0; dec_b = '0; dec_rbd = '0; end
    endcase
  end

  // A load still in ID/EX cannot feed a consumer yet; r0 sources never depend on it.
  logic hazard, halted, accept;
  assign hazard = out_valid && mem_rd && in_valid &&
                  ((reads_a && (reg_a != '0) && (reg_a == dest_reg)) ||
                   (reads_b && (reg_b != '0) && (reg_b == dest_reg)));
  assign in_ready = !halted && !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  // Flush beats everything but reset; a flushed halt entry releases the stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid         <= 1'b0;
      halted            <= 1'b0;
      aluValA           <= '0;
      aluValB           <= '0;
      CONTROL_OPERATION <= ALU_ADD;
      offsetExtended    <= '0;
      pcPrev            <= '0;
      regB_data         <= '0;
      dest_reg          <= '0;
      wr_en             <= 1'b0;
      mem_rd            <= 1'b0;
      mem_wr            <= 1'b0;
      is_beq            <= 1'b0;
      is_jalr           <= 1'b0;
      halt              <= 1'b0;
    end else if (flush || (!accept && out_ready)) begin
      if (flush && out_valid && halt) halted <= 1'b0;
      out_valid <= 1'b0;
      wr_en     <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      is_beq    <= 1'b0;
      is_jalr   <= 1'b0;
      halt      <= 1'b0;
    end else if (accept) begin
      if (dec_halt) halted <= 1'b1;
      out_valid         <= 1'b1;
      aluValA           <= dec_a;
      aluValB           <= dec_b;
      CONTROL_OPERATION <= dec_op;
      offsetExtended    <= off_ext;
      pcPrev            <= in_pc;
      regB_data         <= dec_rbd;
      dest_reg          <= dec_dest;
      wr_en             <= dec_wr;
      mem_rd            <= dec_mrd;
      mem_wr            <= dec_mwr;
      is_beq            <= dec_beq;
      is_jalr           <= dec_jalr;
      halt              <= dec_halt;
    end
  end

endmodule
